// File: rtl/alarm_sched.sv
// Alarm state machine (ring / snooze / stop / timeout) and hourly chime window,
// arbitrated onto registered, glitch-free tone requests; the alarm masks the chime.
module alarm_sched #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int CHIME_SECS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic [7:0] hour1,
  input  logic [7:0] min1,
  input  logic [7:0] sec1,
  input  logic [7:0] ahour,
  input  logic [7:0] amin,
  input  logic       alarm_en,
  input  logic       chime_en,
  input  logic       key_stop,
  input  logic       key_snooze,
  output logic       ring_on,
  output logic       chime_on,
  output logic [1:0] state,
  output logic [2:0] snooze_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  localparam logic [8:0] RING_LD   = 9'(RING_SECS);
  localparam logic [8:0] SNOOZE_LD = 9'(SNOOZE_SECS);
  localparam logic [2:0] MAX_SNZ   = 3'(MAX_SNOOZE);
  localparam logic [3:0] CHIME_LD  = 4'(CHIME_SECS);

  state_t     state_q, state_d;
  logic [8:0] timer_q, timer_d;
  logic [2:0] snooze_cnt_q, snooze_cnt_d;
  logic [3:0] chime_cnt_q, chime_cnt_d;
  logic       match_dly_q, match_dly_d;
  logic       top_dly_q, top_dly_d;
  logic       ring_on_q, ring_on_d;
  logic       chime_on_q, chime_on_d;

  logic match, top, trigger, new_hour;

  always_comb begin
    match    = alarm_en && (hour1 == ahour) && (min1 == amin);
    top      = chime_en && (min1 == 8'h00) && (sec1 == 8'h00);
    trigger  = match && !match_dly_q;
    new_hour = top && !top_dly_q;

    state_d      = state_q;
    timer_d      = timer_q;
    snooze_cnt_d = snooze_cnt_q;
    match_dly_d  = match;
    top_dly_d    = top;

    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d      = S_RING;
          timer_d      = RING_LD;
          snooze_cnt_d = 3'd0;
        end
      end
      S_RING: begin
        if (!alarm_en || key_stop) begin
          state_d      = S_IDLE;
          snooze_cnt_d = 3'd0;
        end else if (key_snooze && (snooze_cnt_q < MAX_SNZ)) begin
          state_d      = S_SNOOZE;
          timer_d      = SNOOZE_LD;
          snooze_cnt_d = snooze_cnt_q + 3'd1;
        end else if (tick_1s) begin
          // The tick that would bring the timer to zero performs the timeout.
          if (timer_q <= 9'd1) begin
            state_d      = S_IDLE;
            snooze_cnt_d = 3'd0;
          end else begin
            timer_d = timer_q - 9'd1;
          end
        end
      end
      S_SNOOZE: begin
        if (!alarm_en || key_stop) begin
          state_d      = S_IDLE;
          snooze_cnt_d = 3'd0;
        end else if (tick_1s) begin
          if (timer_q <= 9'd1) begin
            state_d = S_RING;
            timer_d = RING_LD;
          end else begin
            timer_d = timer_q - 9'd1;
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        snooze_cnt_d = 3'd0;
      end
    endcase

    // A fresh top-of-hour reload wins over the countdown tick of the same cycle.
    chime_cnt_d = chime_cnt_q;
    if (!chime_en) begin
      chime_cnt_d = 4'd0;
    end else if (new_hour) begin
      chime_cnt_d = CHIME_LD;
    end else if (tick_1s && (chime_cnt_q != 4'd0)) begin
      chime_cnt_d = chime_cnt_q - 4'd1;
    end

    ring_on_d  = (state_d == S_RING);
    chime_on_d = (chime_cnt_d != 4'd0) && (state_d != S_RING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= 9'd0;
      snooze_cnt_q <= 3'd0;
      chime_cnt_q  <= 4'd0;
      // Park the edge detector on the live match so a minute still held
      // across reset does not fire the alarm a second time.
      match_dly_q  <= match;
      top_dly_q    <= 1'b0;
      ring_on_q    <= 1'b0;
      chime_on_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      snooze_cnt_q <= snooze_cnt_d;
      chime_cnt_q  <= chime_cnt_d;
      match_dly_q  <= match_dly_d;
      top_dly_q    <= top_dly_d;
      ring_on_q    <= ring_on_d;
      chime_on_q   <= chime_on_d;
    end
  end

  assign ring_on    = ring_on_q;
  assign chime_on   = chime_on_q;
  assign state      = state_q;
  assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_sched.sv
// Bench for alarm_sched: directed sequences, a vector table and a randomized run,
// all checked cycle by cycle against a behavioural model of the alarm and chime rules.
module tb_alarm_sched;

  localparam int RING   = 60;
  localparam int SNZ    = 300;
  localparam int MAXS   = 3;
  localparam int CHIMES = 2;

  logic       clk;
  logic       rst;
  logic       tick_1s;
  logic [7:0] hour1, min1, sec1, ahour, amin;
  logic       alarm_en, chime_en, key_stop, key_snooze;
  logic       ring_on, chime_on;
  logic [1:0] state;
  logic [2:0] snooze_cnt;

  int th, tm, ts, ah, am;
  int total, bad;

  // behavioural model
  int m_mode, m_left, m_snz, m_chime;
  bit m_seen_match, m_seen_top;

  typedef struct {
    bit ae; bit stop; bit snz; bit tk;
    int st; int sc; bit rg;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  assign hour1 = bcd(th);
  assign min1  = bcd(tm);
  assign sec1  = bcd(ts);
  assign ahour = bcd(ah);
  assign amin  = bcd(am);

  alarm_sched #(
    .RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS), .CHIME_SECS(CHIMES)
  ) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s),
    .hour1(hour1), .min1(min1), .sec1(sec1), .ahour(ahour), .amin(amin),
    .alarm_en(alarm_en), .chime_en(chime_en),
    .key_stop(key_stop), .key_snooze(key_snooze),
    .ring_on(ring_on), .chime_on(chime_on), .state(state), .snooze_cnt(snooze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the rules, evaluated on the inputs presented for this edge.
  task automatic model_update();
    bit match, top, trig, newhour;
    match = alarm_en && (th == ah) && (tm == am);
    top   = chime_en && (tm == 0) && (ts == 0);
    if (rst) begin
      m_mode = 0; m_left = 0; m_snz = 0; m_chime = 0;
      m_seen_match = match; m_seen_top = 0;
      return;
    end
    trig = match && !m_seen_match;  m_seen_match = match;
    newhour = top && !m_seen_top;   m_seen_top = top;
    if (m_mode == 0) begin
      if (trig) begin m_mode = 1; m_left = RING; m_snz = 0; end
    end else if (m_mode == 1) begin
      if (!alarm_en || key_stop) begin m_mode = 0; m_snz = 0; end
      else if (key_snooze && m_snz < MAXS) begin m_mode = 2; m_left = SNZ; m_snz++; end
      else if (tick_1s) begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_snz = 0; end
      end
    end else begin
      if (!alarm_en || key_stop) begin m_mode = 0; m_snz = 0; end
      else if (tick_1s) begin
        m_left--;
        if (m_left == 0) begin m_mode = 1; m_left = RING; end
      end
    end
    if (!chime_en) m_chime = 0;
    else if (newhour) m_chime = CHIMES;
    else if (tick_1s && m_chime > 0) m_chime--;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("mdl_state", int'(state), m_mode);
    check("mdl_ring", int'(ring_on), (m_mode == 1) ? 1 : 0);
    check("mdl_chime", int'(chime_on), (m_chime > 0 && m_mode != 1) ? 1 : 0);
    check("mdl_snz", int'(snooze_cnt), m_snz);
  endtask

  task automatic advance_time();
    ts++;
    if (ts == 60) begin ts = 0; tm++; end
    if (tm == 60) begin tm = 0; th++; end
    if (th == 24) th = 0;
  endtask

  task automatic do_tick();
    advance_time();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    step();
  endtask

  task automatic press_stop();
    key_stop = 1'b1; step(); key_stop = 1'b0;
  endtask

  task automatic press_snooze();
    key_snooze = 1'b1; step(); key_snooze = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    m_mode = 0; m_left = 0; m_snz = 0; m_chime = 0; m_seen_match = 0; m_seen_top = 0;

    tbl[0]  = '{1, 0, 1, 0, 1, 3, 1};
    tbl[1]  = '{1, 0, 0, 1, 1, 3, 1};
    tbl[2]  = '{1, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 1, 0, 1};
    tbl[5]  = '{1, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 1, 0, 1};
    tbl[9]  = '{1, 0, 1, 0, 2, 1, 0};
    tbl[10] = '{1, 0, 1, 0, 2, 1, 0};
    tbl[11] = '{1, 0, 0, 1, 2, 1, 0};
    tbl[12] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 1, 0, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; tick_1s = 1'b0; key_stop = 1'b0; key_snooze = 1'b0;
    alarm_en = 1'b1; chime_en = 1'b0;
    th = 7; tm = 29; ts = 58; ah = 7; am = 30;
    step(); step();
    check("rst_state", int'(state), 0);
    check("rst_ring", int'(ring_on), 0);
    check("rst_chime", int'(chime_on), 0);
    check("rst_snz", int'(snooze_cnt), 0);
    rst = 1'b0;

    // 1: fire at 07:30:00, auto-stop on the 60th tick
    do_tick();
    advance_time();
    tick_1s = 1'b1; step(); tick_1s = 1'b0;
    check("t1_ring_next_clk", int'(ring_on), 1);
    check("t1_state_ring", int'(state), 1);
    step();
    for (int i = 0; i < RING - 1; i++) do_tick();
    check("t1_ring_59", int'(ring_on), 1);
    do_tick();
    check("t1_ring_60", int'(ring_on), 0);
    check("t1_state_60", int'(state), 0);
    check("t1_snz_60", int'(snooze_cnt), 0);

    // 2: arm at the current minute, snooze, wake after 300 ticks
    am = tm; step();
    check("t2_fire_now", int'(ring_on), 1);
    press_snooze();
    check("t2_snz_state", int'(state), 2);
    check("t2_snz_cnt", int'(snooze_cnt), 1);
    check("t2_snz_ring", int'(ring_on), 0);
    for (int i = 0; i < SNZ - 1; i++) do_tick();
    check("t2_snz_299", int'(state), 2);
    do_tick();
    check("t2_wake_state", int'(state), 1);
    check("t2_wake_ring", int'(ring_on), 1);

    // 3: use up the snoozes
    for (int k = 2; k <= MAXS; k++) begin
      press_snooze();
      check("t3_snz_cnt", int'(snooze_cnt), k);
      for (int i = 0; i < SNZ; i++) do_tick();
      check("t3_wake", int'(state), 1);
    end
    ah = th; am = tm; step();
    check("t3_retrig_ignored", int'(state), 1);
    check("t3_retrig_snz", int'(snooze_cnt), MAXS);

    for (int i = 0; i < 16; i++) begin
      alarm_en = tbl[i].ae; key_stop = tbl[i].stop;
      key_snooze = tbl[i].snz; tick_1s = tbl[i].tk;
      step();
      check($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
      check($sformatf("tbl%0d_snz", i), int'(snooze_cnt), tbl[i].sc);
      check($sformatf("tbl%0d_ring", i), int'(ring_on), int'(tbl[i].rg));
    end
    key_stop = 1'b0; key_snooze = 1'b0; tick_1s = 1'b0; alarm_en = 1'b0;

    // 5: chime window, then the same hour masked by the alarm
    chime_en = 1'b1; th = 8; tm = 59; ts = 59; step();
    do_tick();
    check("t5_chime_on", int'(chime_on), 1);
    do_tick();
    check("t5_chime_tick1", int'(chime_on), 1);
    do_tick();
    check("t5_chime_tick2", int'(chime_on), 0);
    th = 8; tm = 59; ts = 59; ah = 9; am = 0; alarm_en = 1'b1; step();
    do_tick();
    check("t5_alarm_ring", int'(ring_on), 1);
    check("t5_alarm_chime", int'(chime_on), 0);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check("t5_masked", int'(chime_on), 0);
    end
    press_stop();
    check("t5_lost_chime", int'(chime_on), 0);

    // 6: reset mid-ring, no refire while the minute is held
    alarm_en = 1'b0; step(); alarm_en = 1'b1; step();
    check("t6_ring", int'(ring_on), 1);
    for (int i = 0; i < RING - 20; i++) do_tick();
    check("t6_ring_t20", int'(ring_on), 1);
    rst = 1'b1; step();
    check("t6_rst_state", int'(state), 0);
    check("t6_rst_ring", int'(ring_on), 0);
    check("t6_rst_chime", int'(chime_on), 0);
    check("t6_rst_snz", int'(snooze_cnt), 0);
    rst = 1'b0; step(); step();
    for (int i = 0; i < 5; i++) do_tick();
    check("t6_no_refire", int'(state), 0);
    for (int i = 0; i < 120 && tm == 0; i++) do_tick();
    check("t6_minute_moved", int'(state), 0);
    am = tm; step();
    check("t6_refire", int'(ring_on), 1);
    press_stop();

    // randomized run against the model
    alarm_en = 1'b1; chime_en = 1'b1;
    th = 10; tm = 58; ts = 30; ah = 10; am = 59;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      tick_1s = ($urandom_range(0, 2) == 0);
      if (tick_1s) advance_time();
      key_stop = ($urandom_range(0, 59) == 0);
      key_snooze = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) alarm_en = !alarm_en;
      if ($urandom_range(0, 499) == 0) chime_en = !chime_en;
      if ($urandom_range(0, 149) == 0) begin
        ah = th; am = (tm + $urandom_range(0, 1)) % 60;
      end
      step();
    end
    rst = 1'b0; tick_1s = 1'b0; key_stop = 1'b0; key_snooze = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
